// File: rtl/coeff_bank_if.sv
// Coefficient bank bus: the loader-side request channel plus the bank
// contents and status flags returned to the loader and MAC datapath.
interface coeff_bank_if #(
    parameter int COEFF_W = 16
);
    logic                      load_coeff;
    logic [1:0]                coefficient_num;
    logic signed [COEFF_W-1:0] coeff_data;
    logic                      filter_busy;
    logic                      modwait;
    logic                      clear_new_coeff;
    logic                      coeff_valid;
    logic [4*COEFF_W-1:0]      coeff_out;
    logic                      load_err;

    modport master (
        output load_coeff, coefficient_num, coeff_data, filter_busy,
        input  modwait, clear_new_coeff, coeff_valid, coeff_out, load_err
    );

    modport slave (
        input  load_coeff, coefficient_num, coeff_data, filter_busy,
        output modwait, clear_new_coeff, coeff_valid, coeff_out, load_err
    );
endinterface

// File: rtl/coeff_bank_ctrl.sv
// Coefficient bank controller: accepts one coefficient per load_coeff pulse,
// defers the write while the datapath is mid-sample, paces it over
// LOAD_CYCLES write cycles and commits it into a four-entry bank.
module coeff_bank_ctrl #(
    parameter int COEFF_W     = 16,
    parameter int LOAD_CYCLES = 3
) (
    input  logic         clk,
    input  logic         n_reset,
    coeff_bank_if.slave  bus
);
    localparam int             CNT_W    = $clog2(LOAD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEFER = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_nxt;
    logic                      accept;
    logic                      commit;
    logic [1:0]                hold_num;
    logic signed [COEFF_W-1:0] hold_data;
    logic signed [COEFF_W-1:0] bank [4];

    // Next-state, write-pacing counter and accept/commit strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_coeff) begin
                    accept = 1'b1;
                    if (bus.filter_busy) begin
                        state_nxt = DEFER;
                    end else begin
                        state_nxt = WRITE;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            DEFER: begin
                if (!bus.filter_busy) begin
                    state_nxt = WRITE;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WRITE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The loader must see busy in the very cycle it raises a request.
    assign bus.modwait = (state != IDLE) | bus.load_coeff;

    // State register and write-pacing counter.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request; requests arriving outside IDLE never reach here.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            hold_num  <= '0;
            hold_data <= '0;
        end else if (accept) begin
            hold_num  <= bus.coefficient_num;
            hold_data <= bus.coeff_data;
        end
    end

    // Bank storage; a reset discards any write still in flight.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 4; i++) begin
                bank[i] <= '0;
            end
        end else if (commit) begin
            bank[hold_num] <= hold_data;
        end
    end

    // Status flags: set-complete pulse, set-valid level and rejected-request pulse.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            bus.clear_new_coeff <= 1'b0;
            bus.coeff_valid     <= 1'b0;
            bus.load_err        <= 1'b0;
        end else begin
            bus.clear_new_coeff <= commit && (hold_num == 2'd3);
            bus.load_err        <= bus.load_coeff && (state != IDLE);
            if (commit && (hold_num == 2'd3)) begin
                bus.coeff_valid <= 1'b1;
            end else if (accept && (bus.coefficient_num == 2'd0)) begin
                bus.coeff_valid <= 1'b0;
            end
        end
    end

    // Flatten the bank onto the output bus, entry n at bits [n*COEFF_W +: COEFF_W].
    always_comb begin
        bus.coeff_out = '0;
        for (int i = 0; i < 4; i++) begin
            bus.coeff_out[i*COEFF_W +: COEFF_W] = bank[i];
        end
    end
endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// Testbench for coeff_bank_ctrl: reset/single-load vector table, directed
// multi-cycle sequences and randomized traffic against a timeline model.
module tb_coeff_bank_ctrl;
    localparam int COEFF_W = 16;
    localparam int LC      = 3;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    coeff_bank_if #(.COEFF_W(COEFF_W)) bus ();

    coeff_bank_ctrl #(.COEFF_W(COEFF_W), .LOAD_CYCLES(LC)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a request is pending from its accept edge until the
    // edge that ends cycle commit_at; a deferred request gets its commit
    // time once filter_busy is seen low.
    logic [15:0] m_bank [4];
    bit          m_valid, m_clr, m_err, m_busy, m_defer;
    int          m_commit_at;
    int          cyc;
    logic [1:0]  m_num;
    logic [15:0] m_data;

    typedef struct {
        bit          rst_n;
        bit          ld;
        logic [1:0]  num;
        logic [15:0] data;
        bit          fb;
        bit          e_mw;
        bit          e_clr;
        bit          e_valid;
        bit          e_err;
        logic [63:0] e_out;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] m_out();
        return {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
    endfunction

    task automatic model_edge();
        if (!n_reset) begin
            for (int i = 0; i < 4; i++) m_bank[i] = '0;
            m_valid = 0; m_clr = 0; m_err = 0; m_busy = 0; m_defer = 0;
            m_num = '0; m_data = '0;
        end else begin
            m_clr = 0;
            m_err = bus.load_coeff && m_busy;
            if (m_busy) begin
                if (m_defer) begin
                    if (!bus.filter_busy) begin
                        m_defer     = 0;
                        m_commit_at = cyc + LC;
                    end
                end else if (cyc == m_commit_at) begin
                    m_bank[m_num] = m_data;
                    m_busy        = 0;
                    if (m_num == 2'd3) begin
                        m_clr   = 1;
                        m_valid = 1;
                    end
                end
            end else if (bus.load_coeff) begin
                m_num       = bus.coefficient_num;
                m_data      = bus.coeff_data;
                m_busy      = 1;
                m_defer     = bus.filter_busy;
                m_commit_at = cyc + LC;
                if (bus.coefficient_num == 2'd0) m_valid = 0;
            end
        end
        cyc++;
    endtask

    task automatic drive(input bit rst_n, input bit ld, input logic [1:0] num,
                         input logic [15:0] data, input bit fb);
        n_reset             = rst_n;
        bus.load_coeff      = ld;
        bus.coefficient_num = num;
        bus.coeff_data      = data;
        bus.filter_busy     = fb;
    endtask

    task automatic sample();
        @(negedge clk);
        check("modwait", bus.modwait, m_busy || bus.load_coeff);
        check("clear_new_coeff", bus.clear_new_coeff, m_clr);
        check("coeff_valid", bus.coeff_valid, m_valid);
        check("load_err", bus.load_err, m_err);
        check("coeff_out", bus.coeff_out, m_out());
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          mw [16];
        bit          er [16];
        bit          cl [16];
        logic [15:0] e1 [16];
        logic [15:0] e2 [16];
        logic [63:0] ov [16];
        int          clr_cnt;
        bit          fb;

        tbl[0] = '{0, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 0, 64'h0};
        tbl[1] = '{0, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 0, 64'h0};
        tbl[2] = '{1, 1, 2'd1, 16'h1234, 0, 1, 0, 0, 0, 64'h0};
        tbl[3] = '{1, 0, 2'd0, 16'h0000, 0, 1, 0, 0, 0, 64'h0};
        tbl[4] = '{1, 0, 2'd0, 16'h0000, 0, 1, 0, 0, 0, 64'h0};
        tbl[5] = '{1, 0, 2'd0, 16'h0000, 0, 1, 0, 0, 0, 64'h0};
        tbl[6] = '{1, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 0, 64'h0000_0000_1234_0000};
        tbl[7] = '{1, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 0, 64'h0000_0000_1234_0000};

        cyc = 0;
        drive(0, 0, 2'd0, 16'h0, 0);
        advance();

        // Reset values and single load of entry 1.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].rst_n, tbl[i].ld, tbl[i].num, tbl[i].data, tbl[i].fb);
            sample();
            check("tbl_modwait", bus.modwait, tbl[i].e_mw);
            check("tbl_clear", bus.clear_new_coeff, tbl[i].e_clr);
            check("tbl_valid", bus.coeff_valid, tbl[i].e_valid);
            check("tbl_err", bus.load_err, tbl[i].e_err);
            check("tbl_out", bus.coeff_out, tbl[i].e_out);
            advance();
        end

        // Full set, twice, each request issued the cycle modwait falls.
        for (int pass = 0; pass < 2; pass++) begin
            clr_cnt = 0;
            for (int k = 0; k < 4; k++) begin
                drive(1, 1, 2'(k), 16'h000A + 16'(k), 0);
                sample();
                if (k == 0 && pass == 1) check("valid_before_set", bus.coeff_valid, 1'b1);
                advance();
                drive(1, 0, 2'd0, 16'h0, 0);
                for (int j = 0; j < LC; j++) begin
                    sample();
                    if (k == 0 && j == 0) check("valid_drop", bus.coeff_valid, 1'b0);
                    clr_cnt += int'(bus.clear_new_coeff);
                    advance();
                end
            end
            sample();
            clr_cnt += int'(bus.clear_new_coeff);
            check("set_valid", bus.coeff_valid, 1'b1);
            check("set_out", bus.coeff_out, 64'h000D_000C_000B_000A);
            advance();
            sample();
            clr_cnt += int'(bus.clear_new_coeff);
            advance();
            check("clear_pulse_count", clr_cnt, 1);
        end

        // Deferred write: filter_busy high in cycles 0-4.
        for (int c = 0; c < 11; c++) begin
            drive(1, c == 0, 2'd2, 16'h55AA, c <= 4);
            sample();
            mw[c] = bus.modwait;
            e2[c] = bus.coeff_out[47:32];
            advance();
        end
        check("defer_mw0", mw[0], 1'b1);
        check("defer_mw8", mw[8], 1'b1);
        check("defer_mw9", mw[9], 1'b0);
        check("defer_e2_8", e2[8], 16'h000C);
        check("defer_e2_9", e2[9], 16'h55AA);

        // Second request at cycle 2 while the first is in WRITE.
        for (int c = 0; c < 7; c++) begin
            drive(1, c == 0 || c == 2, c == 0 ? 2'd1 : 2'd2, c == 0 ? 16'h1111 : 16'h2222, 0);
            sample();
            mw[c] = bus.modwait;
            er[c] = bus.load_err;
            e1[c] = bus.coeff_out[31:16];
            e2[c] = bus.coeff_out[47:32];
            advance();
        end
        check("viol_err2", er[2], 1'b0);
        check("viol_err3", er[3], 1'b1);
        check("viol_err4", er[4], 1'b0);
        check("viol_e1_3", e1[3], 16'h000B);
        check("viol_e1_4", e1[4], 16'h1111);
        check("viol_mw4", mw[4], 1'b0);
        check("viol_e2_6", e2[6], 16'h55AA);

        // Reset at cycle 2 of an entry 3 load.
        for (int c = 0; c < 7; c++) begin
            drive(c != 2, c == 0, 2'd3, 16'h3333, 0);
            sample();
            mw[c] = bus.modwait;
            cl[c] = bus.clear_new_coeff;
            ov[c] = bus.coeff_out;
            advance();
        end
        check("rst_mw3", mw[3], 1'b0);
        check("rst_out3", ov[3], 64'h0);
        check("rst_clr", {cl[3], cl[4], cl[5], cl[6]}, 4'b0000);
        check("rst_out6", ov[6], 64'h0);

        // Randomized traffic.
        fb = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) fb = ~fb;
            drive($urandom_range(0, 149) != 0, $urandom_range(0, 2) == 0,
                  2'($urandom_range(0, 3)), 16'($urandom), fb);
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
